// File: rtl/sub_seq_multibyte_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sub_seq_multibyte_pkg
// Brief    : Shared constants and state encoding for the byte-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package sub_seq_multibyte_pkg;

  // Default width of one arithmetic slice
  localparam int C_SLICE_WIDTH = 8;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sub_slice_8_bit.sv
`default_nettype none
// ============================================================================
// Module   : sub_slice_8_bit
// Brief    : Combinational single-slice subtractor with borrow in/out.
// Revision : 1.0 - initial release
// ============================================================================
module sub_slice_8_bit
  import sub_seq_multibyte_pkg::*;
#(
  parameter int PA_DATA_WIDTH = C_SLICE_WIDTH
) (
  input  logic [PA_DATA_WIDTH-1:0] a,
  input  logic [PA_DATA_WIDTH-1:0] b,
  input  logic                     borrow_in,
  output logic [PA_DATA_WIDTH-1:0] diff,
  output logic                     borrow_out
);

  // One extra bit on top catches the borrow out of this slice
  assign {borrow_out, diff} = {1'b0, a} - {1'b0, b} - {{PA_DATA_WIDTH{1'b0}}, borrow_in};

endmodule
`default_nettype wire

// File: rtl/sub_seq_multibyte.sv
`default_nettype none
// ============================================================================
// Module   : sub_seq_multibyte
// Brief    : Multi-cycle byte-serial subtractor, LS slice first, borrow
//            chained between slices, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sub_seq_multibyte
  import sub_seq_multibyte_pkg::*;
#(
  parameter int PA_DATA_WIDTH = C_SLICE_WIDTH,
  parameter int PA_NUM_BYTES  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_b,
  input  logic                                  start,
  input  logic [PA_DATA_WIDTH*PA_NUM_BYTES-1:0] operand_a,
  input  logic [PA_DATA_WIDTH*PA_NUM_BYTES-1:0] operand_b,
  input  logic                                  borrow_in,
  output logic                                  busy,
  output logic                                  done,
  output logic [PA_DATA_WIDTH*PA_NUM_BYTES-1:0] diff_out,
  output logic                                  borrow_out,
  output logic                                  zero_out
);

  localparam int c_total_w = PA_DATA_WIDTH * PA_NUM_BYTES;
  localparam int c_idx_w   = (PA_NUM_BYTES > 1) ? $clog2(PA_NUM_BYTES) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PA_NUM_BYTES - 1);

  state_t                   r_state;
  logic [c_idx_w-1:0]       r_idx;
  logic [c_total_w-1:0]     r_op_a;
  logic [c_total_w-1:0]     r_op_b;
  logic [c_total_w-1:0]     r_acc;
  logic                     r_borrow;

  logic [PA_DATA_WIDTH-1:0] w_a_slice;
  logic [PA_DATA_WIDTH-1:0] w_b_slice;
  logic [PA_DATA_WIDTH-1:0] w_diff;
  logic                     w_borrow_next;
  logic [c_total_w-1:0]     w_acc_next;

  assign w_a_slice = r_op_a[r_idx*PA_DATA_WIDTH +: PA_DATA_WIDTH];
  assign w_b_slice = r_op_b[r_idx*PA_DATA_WIDTH +: PA_DATA_WIDTH];

  sub_slice_8_bit #(
    .PA_DATA_WIDTH (PA_DATA_WIDTH)
  ) u_slice (
    .a          (w_a_slice),
    .b          (w_b_slice),
    .borrow_in  (r_borrow),
    .diff       (w_diff),
    .borrow_out (w_borrow_next)
  );

  // Accumulator with the current slice result merged in; on the last slice
  // this is the complete difference that loads straight into diff_out
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_idx*PA_DATA_WIDTH +: PA_DATA_WIDTH] = w_diff;
  end

  // Sequencer: capture on start, one slice per clock, publish on DONE entry
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_acc      <= '0;
      r_borrow   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
      zero_out   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state  <= ST_RUN;
            r_op_a   <= operand_a;
            r_op_b   <= operand_b;
            r_borrow <= borrow_in;
            r_idx    <= '0;
            r_acc    <= '0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          r_acc    <= w_acc_next;
          r_borrow <= w_borrow_next;
          if (r_idx == c_last_idx) begin
            r_state    <= ST_DONE;
            done       <= 1'b1;
            diff_out   <= w_acc_next;
            borrow_out <= w_borrow_next;
            zero_out   <= (w_acc_next == '0);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sub_seq_multibyte.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_seq_multibyte
// Brief    : Self-checking bench for sub_seq_multibyte (W=8, N=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_seq_multibyte;

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        borrow_in;
  logic        busy;
  logic        done;
  logic [31:0] diff_out;
  logic        borrow_out;
  logic        zero_out;

  int   checks;
  int   failures;
  exp_t sb[$];

  sub_seq_multibyte #(
    .PA_DATA_WIDTH (8),
    .PA_NUM_BYTES  (4)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .start      (start),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff_out   (diff_out),
    .borrow_out (borrow_out),
    .zero_out   (zero_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width unsigned subtraction with a 33rd bit for the borrow
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] t;
    exp_t        e;
    t    = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    e.d  = t[31:0];
    e.bo = t[32];
    e.z  = (t[31:0] == 32'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation and check latency, busy window, held outputs and
  // the scoreboard result. With inj set, start is re-pulsed with a different
  // operand during RUN and DONE, and the operand inputs change after accept.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic inj);
    int          lat;
    int          bc;
    int          chg;
    logic [31:0] prev;
    exp_t        e;
    prev      = diff_out;
    operand_a = a;
    operand_b = b;
    borrow_in = bin;
    start     = 1'b1;
    sb.push_back(model(a, b, bin));
    @(posedge clk);
    #1;
    start = 1'b0;
    if (inj) operand_a = 32'hFFFF_FFFF;
    lat = -1;
    bc  = 0;
    chg = 0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
      if (diff_out !== prev) chg++;
      start = (inj && k == 1);
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_held"}, chg, 0);
    e = sb.pop_front();
    check({tag, "_diff"}, diff_out, e.d);
    check({tag, "_borrow"}, borrow_out, e.bo);
    check({tag, "_zero"}, zero_out, e.z);
    if (inj) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (busy) bc++;
    check({tag, "_done_width"}, done, 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_busy_cycles"}, bc, 5);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_b     = 1'b0;
    start     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff_out, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_zero", zero_out, 0);
    rst_b = 1'b1;
    @(negedge clk);

    run_op("basic", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    run_op("absorb", 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0);
    run_op("wrap", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    run_op("zero_bin", 32'h1234_5678, 32'h1234_5677, 1'b1, 1'b0);
    run_op("ignore", 32'h0000_000A, 32'h0000_0001, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("ignore_no_restart", busy, 0);
    check("ignore_result_kept", diff_out, 32'h0000_0009);

    // Reset in the middle of an operation, after slice 2 has been computed
    operand_a = 32'h0000_0077;
    operand_b = 32'h0000_0011;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_b = 1'b0;
    start = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff_out, 0);
    check("midrst_zero", zero_out, 0);
    @(negedge clk);
    start = 1'b0;
    rst_b = 1'b1;
    @(negedge clk);
    check("midrst_start_ignored", busy, 0);

    run_op("post_rst", 32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
